// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 16x oversampled UART receiver (8N1, LSB first).
//
// Each bit is split into 16 oversample ticks. The line is sampled on ticks
// 7, 8 and 9, and the bit value is the 2-of-3 majority of those samples.
// A start bit whose vote comes out high is treated as noise: the receiver
// goes back to idle and raises no pulse. A low stop bit reports a framing
// error. After a framing error the receiver waits for the line to go high
// before it will accept another start bit.
//
// Parameters:
//   clk_freq  - system clock frequency in Hz
//   baud_rate - line rate in baud
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   serial line, idle high, asynchronous to clk
//   rx_data   out  [7:0] last correctly framed byte, held until the next good frame
//   rx_done   out  one-cycle pulse when rx_data is updated
//   frame_err out  one-cycle pulse when the stop bit is voted low
module uart_rx_os16 #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int OS_DIV_RAW = clk_freq / (baud_rate * 16);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             samp7_q, samp7_d;
  logic             samp8_q, samp8_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_err_q, frame_err_d;

  logic running;
  logic tick;
  logic vote;
  logic vote_now;
  logic bit_wrap;

  // The bit timebase only runs while a frame is being received.
  assign running  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign tick     = running && (div_q == DIV_LAST);
  // The tick-9 sample is taken straight from rx_s_q, so the vote is ready
  // in the same cycle as tick 9 and acted on at that clock edge.
  assign vote     = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);
  assign vote_now = tick && (tick_cnt_q == 4'd9);
  assign bit_wrap = tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp7_d     = samp7_q;
    samp8_d     = samp8_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (running) begin
      div_d = tick ? '0 : DIV_W'(div_q + 1'b1);
      if (tick) begin
        tick_cnt_d = 4'(tick_cnt_q + 4'd1);
        if (tick_cnt_q == 4'd7) samp7_d = rx_s_q;
        if (tick_cnt_q == 4'd8) samp8_d = rx_s_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Counters stay cleared here, so a frame always starts from tick 0.
        div_d      = '0;
        tick_cnt_d = 4'd0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (vote_now && vote) begin
          state_d = S_IDLE;
        end else if (bit_wrap) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (vote_now) shift_d = {vote, shift_q[7:1]};
        if (bit_wrap) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = 3'(bit_idx_q + 3'd1);
        end
      end
      S_STOP: begin
        // Leaving at tick 9 rather than tick 15 leaves room for a sender
        // whose clock runs slightly fast on back-to-back frames.
        if (vote_now) begin
          if (vote) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        div_d      = '0;
        tick_cnt_d = 4'd0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      tick_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      samp7_q     <= 1'b1;
      samp8_q     <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp7_q     <= samp7_d;
      samp8_q     <= samp8_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampled UART receiver with majority-vote bit sampling, false-start rejection and framing-error reporting. It decodes the serial stream produced by the existing UART transmitter (8N1, LSB first) and replaces the simple single-sample receive path inside the UART top. It is driven from the same system clock as the transmitter and uses the same `clk_freq` / `baud_rate` parameterisation.

## Interface
- `clk_freq`, default 1000000: system clock frequency in Hz.
- `baud_rate`, default 9600: line rate in baud.
- `OS_DIV`, derived as `clk_freq / (baud_rate*16)` with integer truncation, minimum 1 (6 at defaults): system clocks per oversample tick.

- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` output 8: last correctly framed byte, held until the next good frame.
- `rx_done` output 1: one-cycle pulse when `rx_data` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- The divider counter runs 0..OS_DIV-1 and emits `tick` when it wraps. The tick counter runs 0..15 and advances on `tick`. Both are cleared on entering START and are held cleared in IDLE.
- Majority vote: the block samples `rx_s` on ticks 7, 8 and 9 of each bit. The bit value is 1 if 2 or more of those samples are 1.
- State machine:
  - IDLE: `rx_s`==0 -> START.
  - START: after the tick-9 vote, vote=1 -> IDLE (false start, no pulse). Otherwise, at the tick-15 wrap -> DATA, with bit index 0.
  - DATA: after each tick-9 vote, the voted bit shifts into the shift register at the MSB, with the register shifting right (LSB first on the line). At the tick-15 wrap, bit index 7 -> STOP; otherwise the bit index increments.
  - STOP: after the tick-9 vote:
    - vote=1: `rx_data` <= shift register, pulse `rx_done`, -> IDLE.
    - vote=0: pulse `frame_err`, leave `rx_data` unchanged, -> WAIT_HI.
  - WAIT_HI: `rx_s`==1 -> IDLE. A low or break line never starts a new frame here.
- STOP exits at tick 9, not tick 15. This gives back-to-back frames up to 6 ticks of transmitter-to-receiver clock slack.
- `rx_done` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `rx_data`=0x00, `rx_done`=0, `frame_err`=0, state IDLE, synchronizer flops 1, all counters 0. Reset asserted mid-frame aborts the frame with no pulse. After release, the block waits in IDLE for a new start edge.
- Define cycle 0 as the first cycle IDLE sees `rx_s`==0. That is 2 cycles after the `rx` pin falls, because of the synchronizer.
- Tick n (n ≥ 0) occurs at cycle OS_DIV*(n+1).
- The stop-bit vote completes on tick 153 (16*9+9).
- `rx_done` or `frame_err` is high in cycle OS_DIV*154+1 (925 at defaults), i.e. 927 cycles after the pin edge.
- A false start returns to IDLE one cycle after tick 9, at cycle 61 at defaults.
- A single-sample glitch (1 of the 3 votes wrong) in any bit has no effect on the received value.
- A new start bit is accepted from the cycle after `rx_done`.

## Test plan
- Reset, then idle line for 2000 cycles -> `rx_done`=0, `frame_err`=0 and `rx_data`=0x00 throughout.
- Transmitter sends 0xA5, then 0x3C back-to-back (96 clocks per bit) -> two `rx_done` pulses, each exactly 925 cycles after its own cycle 0. `rx_data`=0xA5, then 0x3C.
- `rx` low for 30 cycles in idle, then high -> no pulse, state back to IDLE. A following 0x5A frame is received correctly.
- Frame 0xFF with the stop bit driven low, line then held low 500 cycles, then high -> a single `frame_err` pulse, `rx_data` keeps its previous value. No start is accepted until `rx` returns high, and the next frame 0x81 gives `rx_done` with `rx_data`=0x81.
- Frame 0x00 with `rx` forced high for exactly one oversample tick window (6 cycles) at tick 8 of data bit 3 -> `rx_data`=0x00, `rx_done` pulses.
- `rst` asserted for 3 cycles during data bit 4 of 0xF0 -> outputs reset immediately, no pulse for the partial frame. The next full 0x0F frame gives `rx_data`=0x0F.
